// File: rtl/reg_dump_unit_pkg.sv
// Shared types and sizing for the register-file dump engine.
package reg_dump_unit_pkg;

  localparam int DUMP_BITS = 64;
  localparam int DUMP_N    = 32;
  localparam int DUMP_IW   = $clog2(DUMP_N);

  typedef enum logic [1:0] {
    DUMP_IDLE   = 2'd0,
    DUMP_STREAM = 2'd1,
    DUMP_DRAIN  = 2'd2
  } dump_state_t;

endpackage

// File: rtl/reg_dump_unit.sv
// Debug readout engine: walks every register-file entry through a spare
// read port and streams (index, value) pairs on a valid/ready interface.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// DUMP_IDLE   | waiting for dump_req (ignored during the dump_done cycle)
// DUMP_STREAM | fetching entries 0..N-1, one per accepted/empty output slot
// DUMP_DRAIN  | all entries fetched, holding the last pair until accepted
module reg_dump_unit
  import reg_dump_unit_pkg::*;
#(
  parameter int Bits = DUMP_BITS,
  parameter int N    = DUMP_N,
  localparam int IW  = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dump_req,
  output logic            dump_busy,
  output logic            dump_done,
  output logic [IW-1:0]   rf_raddr,
  input  logic [Bits-1:0] rf_rdata,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [IW-1:0]   dout_idx,
  output logic [Bits-1:0] dout_data,
  output logic            dout_last
);

  localparam logic [IW:0] CNT_N    = (IW+1)'(N);
  localparam logic [IW:0] CNT_LAST = (IW+1)'(N - 1);

  dump_state_t     r_state;
  logic [IW:0]     r_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_valid;
  logic [IW-1:0]   r_idx;
  logic [Bits-1:0] r_data;
  logic            r_last;

  logic w_hs;
  logic w_load;

  // The output register may be refilled when empty or when its pair is
  // being accepted this edge, so a single stage sustains one pair per cycle.
  assign w_hs   = r_valid && dout_ready;
  assign w_load = (r_state == DUMP_STREAM) && (r_cnt < CNT_N) && (!r_valid || dout_ready);

  // Read address only points at the register file while fetching.
  assign rf_raddr = (r_state == DUMP_STREAM) ? r_cnt[IW-1:0] : '0;

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= DUMP_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        DUMP_IDLE: begin
          if (dump_req && !r_done) begin
            r_state <= DUMP_STREAM;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        DUMP_STREAM: begin
          if (w_load) begin
            r_data  <= rf_rdata;
            r_idx   <= r_cnt[IW-1:0];
            r_last  <= (r_cnt == CNT_LAST);
            r_valid <= 1'b1;
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
              r_state <= DUMP_DRAIN;
            end
          end else if (w_hs) begin
            r_valid <= 1'b0;
          end
        end
        DUMP_DRAIN: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            r_state <= DUMP_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= DUMP_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign dump_busy  = r_busy;
  assign dump_done  = r_done;
  assign dout_valid = r_valid;
  assign dout_idx   = r_idx;
  assign dout_data  = r_data;
  assign dout_last  = r_last;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench for reg_dump_unit with a behavioural register file.
module tb_reg_dump_unit;
  import reg_dump_unit_pkg::*;

  localparam int BITS = 64;
  localparam int N    = 32;
  localparam int IW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            dump_req;
  logic            dump_busy;
  logic            dump_done;
  logic [IW-1:0]   rf_raddr;
  logic [BITS-1:0] rf_rdata;
  logic            dout_valid;
  logic            dout_ready;
  logic [IW-1:0]   dout_idx;
  logic [BITS-1:0] dout_data;
  logic            dout_last;

  logic [BITS-1:0] rf    [N];
  logic [BITS-1:0] exp_d [N];

  int n_chk  = 0;
  int n_pass = 0;

  reg_dump_unit #(.Bits(BITS), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .dump_req   (dump_req),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_idx   (dout_idx),
    .dout_data  (dout_data),
    .dout_last  (dout_last)
  );

  assign rf_rdata = rf[rf_raddr];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    for (int i = 0; i < N; i++) begin
      rf[i]    = BITS'(i) * 64'h11;
      exp_d[i] = BITS'(i) * 64'h11;
    end
  endtask

  // mode 0: ready always high; 1: ready 1,0,0 repeating; 2: ready held low
  // for three cycles once the last pair is showing.
  task automatic run_dump(input int mode, input int hook_idx, input logic [63:0] hook_val,
                          input int req_at);
    int              got;
    int              cycles;
    int              hold;
    logic            rdy;
    logic            pv;
    logic [IW-1:0]   p_idx;
    logic [BITS-1:0] p_data;
    logic            p_last;
    got = 0; cycles = 0; hold = 0; pv = 1'b0;
    p_idx = '0; p_data = '0; p_last = 1'b0;
    dump_req = 1'b1;
    cyc();
    dump_req = 1'b0;
    chk("busy_after_req", 64'(dump_busy), 64'd1);
    chk("valid_latency_k1", 64'(dout_valid), 64'd0);
    cyc();
    chk("valid_latency_k2", 64'(dout_valid), 64'd1);
    chk("first_idx", 64'(dout_idx), 64'd0);
    while (got < N && cycles < 400) begin
      if (pv) begin
        chk("stable_valid", 64'(dout_valid), 64'd1);
        chk("stable_idx", 64'(dout_idx), 64'(p_idx));
        chk("stable_data", dout_data, p_data);
        chk("stable_last", 64'(dout_last), 64'(p_last));
      end
      case (mode)
        1: rdy = (cycles % 3 == 0);
        2: begin
          if (dout_valid && dout_idx == IW'(N - 1) && hold < 3) begin
            rdy = 1'b0;
            hold++;
            chk("drain_busy", 64'(dump_busy), 64'd1);
            chk("drain_no_done", 64'(dump_done), 64'd0);
            chk("drain_raddr", 64'(rf_raddr), 64'd0);
          end else begin
            rdy = 1'b1;
          end
        end
        default: rdy = 1'b1;
      endcase
      if (hook_idx > 0 && dout_valid && dout_idx == IW'(hook_idx - 1)) begin
        rf[hook_idx]    = hook_val;
        exp_d[hook_idx] = hook_val;
      end
      dump_req   = (req_at >= 0) && dout_valid && (dout_idx == IW'(req_at));
      dout_ready = rdy;
      if (dout_valid && rdy) begin
        chk("pair_idx", 64'(dout_idx), 64'(got));
        chk("pair_data", dout_data, exp_d[got]);
        chk("pair_last", 64'(dout_last), 64'(got == N - 1));
        got++;
      end
      pv     = dout_valid && !rdy;
      p_idx  = dout_idx;
      p_data = dout_data;
      p_last = dout_last;
      cyc();
      cycles++;
    end
    dump_req = 1'b0;
    chk("pair_count_or_timeout", 64'(got), 64'(N));
    if (mode == 0) chk("no_gaps", 64'(cycles), 64'(N));
    chk("done_pulse", 64'(dump_done), 64'd1);
    chk("busy_clear", 64'(dump_busy), 64'd0);
    chk("valid_clear", 64'(dout_valid), 64'd0);
    // A request during the done cycle must not start a new dump.
    dump_req = 1'b1;
    cyc();
    dump_req = 1'b0;
    chk("done_one_cycle", 64'(dump_done), 64'd0);
    chk("req_in_done_ignored", 64'(dump_busy), 64'd0);
    cyc();
    chk("still_idle", 64'(dump_busy), 64'd0);
    dout_ready = 1'b1;
  endtask

  initial begin
    rst        = 1'b0;
    dump_req   = 1'b0;
    dout_ready = 1'b1;
    preload();
    cyc();
    cyc();
    chk("rst_busy", 64'(dump_busy), 64'd0);
    chk("rst_valid", 64'(dout_valid), 64'd0);
    chk("rst_raddr", 64'(rf_raddr), 64'd0);
    rst = 1'b1;
    cyc();
    chk("idle_busy", 64'(dump_busy), 64'd0);

    // Reset asserted mid-stream aborts the dump.
    dump_req = 1'b1;
    cyc();
    dump_req = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("midstream_valid", 64'(dout_valid), 64'd1);
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(dout_valid), 64'd0);
    chk("arst_busy", 64'(dump_busy), 64'd0);
    chk("arst_idx", 64'(dout_idx), 64'd0);
    chk("arst_data", dout_data, 64'd0);
    chk("arst_last", 64'(dout_last), 64'd0);
    chk("arst_raddr", 64'(rf_raddr), 64'd0);
    chk("arst_done", 64'(dump_done), 64'd0);
    cyc();
    chk("arst_done_c1", 64'(dump_done), 64'd0);
    cyc();
    chk("arst_done_c2", 64'(dump_done), 64'd0);
    rst = 1'b1;
    cyc();
    chk("post_rst_busy", 64'(dump_busy), 64'd0);
    chk("post_rst_valid", 64'(dout_valid), 64'd0);
    chk("post_rst_done", 64'(dump_done), 64'd0);

    // Full dump at full rate.
    run_dump(0, -1, 64'd0, -1);
    // Backpressure 1,0,0 pattern.
    run_dump(1, -1, 64'd0, -1);
    // Re-request mid-dump is ignored, then a second dump works.
    run_dump(0, -1, 64'd0, 10);
    run_dump(0, -1, 64'd0, -1);
    // Core write to x5 just before its fetch is seen in the stream.
    run_dump(0, 5, 64'hDEAD, -1);
    preload();
    // Ready held low after the last load keeps the unit in drain.
    run_dump(2, -1, 64'd0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
